ram_dual_pipe: RTL

Parametrised true dual-port RAM and successor to the basic two-port polynomial-coefficient store. It adds a configurable read latency and explicit read enables with valid strobes. It also adds a selectable same-port write mode, deterministic collision rules, and a built-in clear engine that zeroes the array after reset or on request. It sits between the sampler/multiplier datapaths and the coefficient storage.

---
 rtl/ram_dual_pipe_if.sv | 44 ++++
 rtl/ram_dual_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram_dual_pipe_if.sv
// Bus bundle for ram_dual_pipe: clear/busy control plus two independent read/write ports.
// The collision strobe is present only when RAM_DUAL_COLLISION_EN is defined.
interface ram_dual_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             clear;
  logic             busy;
  logic [WIDTH-1:0] data_0;
  logic [AW-1:0]    address_0;
  logic             wren_0;
  logic             rden_0;
  logic [WIDTH-1:0] q_0;
  logic             valid_0;
  logic [WIDTH-1:0] data_1;
  logic [AW-1:0]    address_1;
  logic             wren_1;
  logic             rden_1;
  logic [WIDTH-1:0] q_1;
  logic             valid_1;
`ifdef RAM_DUAL_COLLISION_EN
  logic             collision;

  modport master (
    output clear, data_0, address_0, wren_0, rden_0, data_1, address_1, wren_1, rden_1,
    input  busy, q_0, valid_0, q_1, valid_1, collision
  );
  modport slave (
    input  clear, data_0, address_0, wren_0, rden_0, data_1, address_1, wren_1, rden_1,
    output busy, q_0, valid_0, q_1, valid_1, collision
  );
`else
  modport master (
    output clear, data_0, address_0, wren_0, rden_0, data_1, address_1, wren_1, rden_1,
    input  busy, q_0, valid_0, q_1, valid_1
  );
  modport slave (
    input  clear, data_0, address_0, wren_0, rden_0, data_1, address_1, wren_1, rden_1,
    output busy, q_0, valid_0, q_1, valid_1
  );
`endif
endinterface

// File: rtl/ram_dual_pipe.sv
// True dual-port coefficient RAM with pipelined reads, valid strobes and a zero-fill clear engine.
// Optional same-address write collision strobe enabled by defining RAM_DUAL_COLLISION_EN.
module ram_dual_pipe #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 64,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            rst,
  ram_dual_pipe_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]       state;
  logic             boot;
  logic [AW-1:0]    clr_addr;
  logic             busy;
  logic             user_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] wdata [2];
  logic [AW-1:0]    addr  [2];
  logic             wren  [2];
  logic             rden  [2];
  logic             in_range [2];
  logic             wr_en [2];
  logic [WIDTH-1:0] q     [2];
  logic             valid [2];

  assign wdata[0] = bus.data_0;
  assign wdata[1] = bus.data_1;
  assign addr[0]  = bus.address_0;
  assign addr[1]  = bus.address_1;
  assign wren[0]  = bus.wren_0;
  assign wren[1]  = bus.wren_1;
  assign rden[0]  = bus.rden_0;
  assign rden[1]  = bus.rden_1;

  assign bus.q_0     = q[0];
  assign bus.q_1     = q[1];
  assign bus.valid_0 = valid[0];
  assign bus.valid_1 = valid[1];

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;
  assign user_ok  = !rst && !busy;

  assign in_range[0] = int'(addr[0]) < DEPTH;
  assign in_range[1] = int'(addr[1]) < DEPTH;

  // Port 0 wins a same-address write, so port 1 is suppressed outright.
  assign wr_en[0] = user_ok && wren[0] && in_range[0];
  assign wr_en[1] = user_ok && wren[1] && in_range[1] && !(wren[0] && addr[0] == addr[1]);

  // `boot` marks the first cycle out of reset so the automatic clear can be launched.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      boot     <= 1'b1;
      clr_addr <= '0;
    end else begin
      boot <= 1'b0;
      case (state)
        IDLE: begin
          if ((boot && CLEAR_ON_RESET != 0) || bus.clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == AW'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; zeroing it is the clear engine's job.
  always_ff @(posedge clk) begin
    if (busy && !rst) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr_en[0]) mem[addr[0]] <= wdata[0];
      if (wr_en[1]) mem[addr[1]] <= wdata[1];
    end
  end

  // Each port: read data captured at the rden edge, then carried through RD_LATENCY-1 stages.
  // Data stages only load behind a valid, so the last stage doubles as the hold register for q.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  fire;
    logic [WIDTH-1:0]      rdata;
    logic [RD_LATENCY-1:0] sv;
    logic [WIDTH-1:0]      sd [RD_LATENCY];

    assign fire  = user_ok && rden[p];
    assign rdata = !in_range[p]                   ? '0 :
                   (WRITE_MODE == 0 && wren[p])   ? wdata[p] :
                                                    mem[addr[p]];

    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= '0;
        for (int i = 0; i < RD_LATENCY; i++) sd[i] <= '0;
      end else begin
        sv[0] <= fire;
        if (fire) sd[0] <= rdata;
        for (int i = 1; i < RD_LATENCY; i++) begin
          sv[i] <= sv[i-1];
          if (sv[i-1]) sd[i] <= sd[i-1];
        end
      end
    end

    assign q[p]     = sd[RD_LATENCY-1];
    assign valid[p] = sv[RD_LATENCY-1];
  end

`ifdef RAM_DUAL_COLLISION_EN
  logic collision;

  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= !busy && wren[0] && wren[1] && (addr[0] == addr[1]);
  end

  assign bus.collision = collision;
`endif
endmodule
